// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame geometry.
// The PARITY state exists only when SPI_TX_PARITY_EN is defined.
package spi_pkg;

    localparam int TXD_BIT_NUM_DEF = 8;
    localparam int CLK_DIV_DEF     = 16;

`ifdef SPI_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } spi_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } spi_state_t;
`endif

endpackage

// File: rtl/spi_bit_tick.sv
// Bit-period divider: while enabled, pulses tick once every CLK_DIV cycles;
// clear restarts the period so the next bit gets its full width.
module spi_bit_tick
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic RST_clk,
    input  logic RST_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge RST_clk or negedge RST_n) begin
        if (!RST_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            if (cnt_reg == LAST_CNT) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign tick = enable && !clear && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/spi_tx.sv
// Serial transmitter: start bit (0), payload LSB first, optional even parity
// bit (macro SPI_TX_PARITY_EN), stop bit (1); every bit lasts CLK_DIV cycles.
module spi_tx
    import spi_pkg::*;
#(
    parameter int TXD_BIT_NUM = TXD_BIT_NUM_DEF,
    parameter int CLK_DIV     = CLK_DIV_DEF
) (
    input  logic                   RST_clk,
    input  logic                   RST_n,
    input  logic [TXD_BIT_NUM-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   spi_tx_data,
    output logic                   tx_busy,
    output logic                   tx_done
);

    localparam int BW = $clog2(TXD_BIT_NUM + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(TXD_BIT_NUM - 1);

    spi_state_t             state_reg;
    logic [TXD_BIT_NUM-1:0] shift_reg;
    logic [BW-1:0]          bit_cnt_reg;
`ifdef SPI_TX_PARITY_EN
    logic                   parity_reg;
`endif

    logic accept;
    logic tick;

    // tx_ready is high exactly in IDLE, so it doubles as the state qualifier.
    assign accept = tx_valid && tx_ready;

    spi_bit_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_tick (
        .RST_clk (RST_clk),
        .RST_n   (RST_n),
        .clear   (accept),
        .enable  (tx_busy),
        .tick    (tick)
    );

    always_ff @(posedge RST_clk or negedge RST_n) begin
        if (!RST_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '1;
            bit_cnt_reg <= '0;
            spi_tx_data <= 1'b1;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
`ifdef SPI_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    spi_tx_data <= 1'b1;
                    if (accept) begin
                        state_reg   <= START;
                        shift_reg   <= tx_data;
                        bit_cnt_reg <= '0;
                        spi_tx_data <= 1'b0;
                        tx_ready    <= 1'b0;
                        tx_busy     <= 1'b1;
`ifdef SPI_TX_PARITY_EN
                        parity_reg  <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state_reg   <= DATA;
                        spi_tx_data <= shift_reg[0];
                        shift_reg   <= TXD_BIT_NUM'({1'b1, shift_reg} >> 1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt_reg == LAST_BIT) begin
`ifdef SPI_TX_PARITY_EN
                            state_reg   <= PARITY;
                            spi_tx_data <= parity_reg;
`else
                            state_reg   <= STOP;
                            spi_tx_data <= 1'b1;
`endif
                        end else begin
                            spi_tx_data <= shift_reg[0];
                            shift_reg   <= TXD_BIT_NUM'({1'b1, shift_reg} >> 1);
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
`ifdef SPI_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state_reg   <= STOP;
                        spi_tx_data <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state_reg   <= IDLE;
                        spi_tx_data <= 1'b1;
                        tx_ready    <= 1'b1;
                        tx_busy     <= 1'b0;
                        tx_done     <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    spi_tx_data <= 1'b1;
                    tx_ready    <= 1'b1;
                    tx_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
